sphere3_pool_arbiter: RTL and testbench
=======================================

Name: sphere3_pool_arbiter

Overview:
- Shares one sphere3_32bit generator (Sphere3 low-discrepancy point source, outputs w/x/y/z) among NUM_REQ requesters.
- Grants round-robin, sequences the pop/valid exchange with the generator, and returns each point to the requester that asked for it.
- Serialises reseed commands against point pops.
- Detects a stuck generator with a watchdog.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of rsp_id; must equal clog2(NUM_REQ).
- TIMEOUT_CYC, 64: maximum cycles to wait for gen_valid before abort.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester point request (level). Held until the matching ack bit pulses.
- ack  out  NUM_REQ  one-hot, one-cycle pulse; coincides with rsp_valid.
- rsp_valid  out  1  response strobe, one cycle.
- rsp_id  out  ID_W  index of the served requester.
- rsp_err  out  1  response aborted by timeout; data is 0.
- rsp_w, rsp_x, rsp_y, rsp_z  out  32 each  latched point coordinates.
- cfg_reseed  in  1  one-cycle reseed command.
- cfg_seed  in  32  seed, sampled with cfg_reseed.
- gen_pop  out  1  drives generator pop_enable.
- gen_reseed  out  1  drives generator reseed_enable.
- gen_seed  out  32  drives generator seed.
- gen_w, gen_x, gen_y, gen_z  in  32 each  generator outputs.
- gen_valid  in  1  generator valid.
- busy  out  1  high in any state other than IDLE.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by rst.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE.
  - All outputs 0: ack, rsp_*, gen_pop, gen_reseed, gen_seed, busy, timeout_flag.
  - Reseed-pending flag cleared; round-robin pointer = 0 (requester 0 has highest priority first).
  - Reset mid-transaction abandons it silently: no ack, and gen_pop drops in the next cycle.
- Reseed capture:
  - cfg_reseed high in any state latches cfg_seed into seed_hold and sets reseed_pend.
  - A second cfg_reseed before service overwrites seed_hold (last wins).
- States:
  - IDLE:
    - If reseed_pend: go to RESEED. Reseed has priority over requests.
    - Else if any req bit is high: pick the first set bit at or after ptr (wrapping modulo NUM_REQ), store it as gid, set ptr=gid+1 (wrap), go to ISSUE.
    - Else stay.
  - RESEED: one cycle. gen_reseed=1, gen_seed=seed_hold, reseed_pend cleared. Then IDLE.
  - ISSUE: gen_pop=1, watchdog=0. Then WAIT.
  - WAIT:
    - gen_pop stays 1; watchdog increments each cycle.
    - gen_valid=1: capture gen_w/x/y/z into the rsp_* registers, drop gen_pop next cycle, go to RESP with rsp_err=0.
    - watchdog reaches TIMEOUT_CYC-1 with gen_valid still 0: zero the rsp_* data, set rsp_err=1, set timeout_flag, go to RESP.
    - gen_valid takes precedence over timeout on the same cycle.
  - RESP: one cycle. rsp_valid=1, rsp_id=gid, ack[gid]=1. Then IDLE.
- Timing:
  - Best-case latency, from req sampled in IDLE to ack: 3 cycles + generator latency.
  - Minimum gap between two grants: 1 IDLE cycle.
- Requester behaviour:
  - A requester that drops req after grant is still served with an ack.
  - A requester that holds req after its ack is treated as a new request, but round-robin places it after the others.
- gen_seed holds its last driven value outside RESEED.
- rsp_* hold their values until the next capture.
- Stray gen_valid outside WAIT is ignored.

Optional Feature:
- Macro: SPHERE3_POOL_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16 bits), one 16-bit saturating counter per requester. The counter increments on that requester's ack when rsp_err=0.
  - Adds output timeout_cnt (16 bits), saturating.
  - All counters reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Single request: req=4'b0001, generator model valid 5 cycles after pop → one ack=0001, rsp_id=0, rsp_err=0, rsp_w/x/y/z match the model outputs. gen_pop is high exactly 6 cycles.
- Fairness: req=4'b1111 held for 8 responses → rsp_id sequence 0,1,2,3,0,1,2,3. Each ack is a single-cycle pulse.
- Reseed priority: cfg_reseed with cfg_seed=5 during WAIT while req=0010 is pending → the current response completes first, then gen_reseed is pulsed for one cycle with gen_seed=5, then requester 1 is granted.
- Timeout: the model never asserts valid → rsp_valid on cycle TIMEOUT_CYC+1 after ISSUE with rsp_err=1, data 0, timeout_flag=1. The next request is served normally and timeout_flag remains 1.
- Reset mid-WAIT: assert rst 3 cycles into WAIT → no ack. The next cycle shows state IDLE, all outputs 0, and requester 0 is granted first afterwards.
- Stats (macro defined): 3 good responses to requester 2 plus 1 timeout → grant_cnt[2]=3, timeout_cnt=1.

Source files
------------

// File: rtl/sphere3_pool_arbiter_if.sv
// Requester / generator bundle for sphere3_pool_arbiter.
// slave  : arbiter view (drives ack, rsp_*, gen_pop/reseed/seed, busy, timeout_flag).
// master : environment view (requesters, config source and generator).
interface sphere3_pool_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_err;
  logic [31:0]        rsp_w;
  logic [31:0]        rsp_x;
  logic [31:0]        rsp_y;
  logic [31:0]        rsp_z;
  logic               cfg_reseed;
  logic [31:0]        cfg_seed;
  logic               gen_pop;
  logic               gen_reseed;
  logic [31:0]        gen_seed;
  logic [31:0]        gen_w;
  logic [31:0]        gen_x;
  logic [31:0]        gen_y;
  logic [31:0]        gen_z;
  logic               gen_valid;
  logic               busy;
  logic               timeout_flag;

  modport slave (
    input  req, cfg_reseed, cfg_seed, gen_w, gen_x, gen_y, gen_z, gen_valid,
    output ack, rsp_valid, rsp_id, rsp_err, rsp_w, rsp_x, rsp_y, rsp_z,
    output gen_pop, gen_reseed, gen_seed, busy, timeout_flag
  );

  modport master (
    output req, cfg_reseed, cfg_seed, gen_w, gen_x, gen_y, gen_z, gen_valid,
    input  ack, rsp_valid, rsp_id, rsp_err, rsp_w, rsp_x, rsp_y, rsp_z,
    input  gen_pop, gen_reseed, gen_seed, busy, timeout_flag
  );
endinterface

// File: rtl/sphere3_pool_arbiter.sv
// Round-robin pool arbiter sharing one sphere3_32bit point generator among
// NUM_REQ requesters, with reseed serialisation and a stuck-generator watchdog.
// Optional macro SPHERE3_POOL_ARBITER_STATS_EN adds per-requester grant
// counters and a timeout counter.
module sphere3_pool_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  sphere3_pool_arbiter_if.slave   bus
`ifdef SPHERE3_POOL_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   grant_cnt,
  output logic [15:0]             timeout_cnt
`endif
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IX_W = ID_W + 1;

  typedef enum logic [2:0] {IDLE, RESEED, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_n;
  logic [ID_W-1:0]    ptr, ptr_n, gid, gid_n, pick_c;
  logic               any_req_c;
  logic [IX_W-1:0]    idx;
  logic [WD_W-1:0]    wd, wd_n;
  logic               reseed_pend, reseed_pend_n;
  logic [31:0]        seed_hold, seed_hold_n;
  logic [NUM_REQ-1:0] ack_n;
  logic               rsp_valid_n, rsp_err_n;
  logic [ID_W-1:0]    rsp_id_n;
  logic [31:0]        w_n, x_n, y_n, z_n;
  logic               gen_pop_n, gen_reseed_n, timeout_flag_n;
  logic [31:0]        gen_seed_n;

  // Round-robin pick: first requesting index at or after ptr, wrapping.
  always_comb begin
    pick_c    = '0;
    any_req_c = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + IX_W'(i);
      if (idx >= IX_W'(NUM_REQ)) idx = idx - IX_W'(NUM_REQ);
      if (!any_req_c && bus.req[idx[ID_W-1:0]]) begin
        any_req_c = 1'b1;
        pick_c    = idx[ID_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n        = state;
    ptr_n          = ptr;
    gid_n          = gid;
    wd_n           = wd;
    reseed_pend_n  = reseed_pend;
    seed_hold_n    = seed_hold;
    ack_n          = '0;
    rsp_valid_n    = 1'b0;
    rsp_id_n       = bus.rsp_id;
    rsp_err_n      = bus.rsp_err;
    w_n            = bus.rsp_w;
    x_n            = bus.rsp_x;
    y_n            = bus.rsp_y;
    z_n            = bus.rsp_z;
    gen_pop_n      = 1'b0;
    gen_reseed_n   = 1'b0;
    gen_seed_n     = bus.gen_seed;
    timeout_flag_n = bus.timeout_flag;

    if (bus.cfg_reseed) begin
      seed_hold_n   = bus.cfg_seed;
      reseed_pend_n = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (reseed_pend) begin
          // A seed arriving this very cycle supersedes the held one.
          state_n       = RESEED;
          gen_reseed_n  = 1'b1;
          gen_seed_n    = bus.cfg_reseed ? bus.cfg_seed : seed_hold;
          reseed_pend_n = 1'b0;
        end else if (any_req_c) begin
          state_n   = ISSUE;
          gid_n     = pick_c;
          ptr_n     = (pick_c == ID_W'(NUM_REQ - 1)) ? '0 : pick_c + ID_W'(1);
          gen_pop_n = 1'b1;
        end
      end
      RESEED: state_n = IDLE;
      ISSUE: begin
        state_n   = WAIT;
        wd_n      = '0;
        gen_pop_n = 1'b1;
      end
      WAIT: begin
        if (bus.gen_valid) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_id_n    = gid;
          rsp_err_n   = 1'b0;
          ack_n       = NUM_REQ'(1) << gid;
          w_n         = bus.gen_w;
          x_n         = bus.gen_x;
          y_n         = bus.gen_y;
          z_n         = bus.gen_z;
        end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
          state_n        = RESP;
          rsp_valid_n    = 1'b1;
          rsp_id_n       = gid;
          rsp_err_n      = 1'b1;
          ack_n          = NUM_REQ'(1) << gid;
          w_n            = '0;
          x_n            = '0;
          y_n            = '0;
          z_n            = '0;
          timeout_flag_n = 1'b1;
        end else begin
          wd_n      = wd + WD_W'(1);
          gen_pop_n = 1'b1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= '0;
      gid              <= '0;
      wd               <= '0;
      reseed_pend      <= 1'b0;
      seed_hold        <= '0;
      bus.ack          <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= '0;
      bus.rsp_err      <= 1'b0;
      bus.rsp_w        <= '0;
      bus.rsp_x        <= '0;
      bus.rsp_y        <= '0;
      bus.rsp_z        <= '0;
      bus.gen_pop      <= 1'b0;
      bus.gen_reseed   <= 1'b0;
      bus.gen_seed     <= '0;
      bus.busy         <= 1'b0;
      bus.timeout_flag <= 1'b0;
    end else begin
      state            <= state_n;
      ptr              <= ptr_n;
      gid              <= gid_n;
      wd               <= wd_n;
      reseed_pend      <= reseed_pend_n;
      seed_hold        <= seed_hold_n;
      bus.ack          <= ack_n;
      bus.rsp_valid    <= rsp_valid_n;
      bus.rsp_id       <= rsp_id_n;
      bus.rsp_err      <= rsp_err_n;
      bus.rsp_w        <= w_n;
      bus.rsp_x        <= x_n;
      bus.rsp_y        <= y_n;
      bus.rsp_z        <= z_n;
      bus.gen_pop      <= gen_pop_n;
      bus.gen_reseed   <= gen_reseed_n;
      bus.gen_seed     <= gen_seed_n;
      bus.busy         <= (state_n != IDLE);
      bus.timeout_flag <= timeout_flag_n;
    end
  end

`ifdef SPHERE3_POOL_ARBITER_STATS_EN
  // Saturating counters updated on each response strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt   <= '0;
      timeout_cnt <= '0;
    end else if (bus.rsp_valid) begin
      if (bus.rsp_err) begin
        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      end else begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (bus.rsp_id == ID_W'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
            grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sphere3_pool_arbiter.sv
// Self-checking bench for sphere3_pool_arbiter: behavioural generator model,
// scoreboard of expected responses, table-driven grants plus corner sequences.
module tb_sphere3_pool_arbiter;
  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned ID_W        = 2;
  localparam int unsigned TIMEOUT_CYC = 64;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } pt_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            err;
    pt_t             d;
  } exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] req;
    int unsigned        lat;
    logic [ID_W-1:0]    id;
    logic               err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sphere3_pool_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

`ifdef SPHERE3_POOL_ARBITER_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic [15:0]           timeout_cnt;
`endif

  sphere3_pool_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SPHERE3_POOL_ARBITER_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .timeout_cnt(timeout_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Deterministic point sequence n -> (w,x,y,z).
  function automatic pt_t point(input int unsigned n);
    pt_t p;
    p.w = 32'h1000_0000 + n;
    p.x = 32'h2000_0000 + n * 7;
    p.y = ~(32'h3000_0000 + n);
    p.z = 32'h4000_0000 ^ (n << 8);
    return p;
  endfunction

  // Generator model: valid after lat consecutive pop cycles (lat=0: never).
  int unsigned lat = 0;
  logic        stray = 1'b0;
  int unsigned pop_cnt = 0;
  int unsigned pt_cnt = 0;
  logic        model_hit;
  pt_t         cur_pt;

  assign model_hit     = bus.gen_pop && (lat != 0) && (pop_cnt == lat);
  assign cur_pt        = point(pt_cnt);
  assign bus.gen_w     = cur_pt.w;
  assign bus.gen_x     = cur_pt.x;
  assign bus.gen_y     = cur_pt.y;
  assign bus.gen_z     = cur_pt.z;
  assign bus.gen_valid = model_hit | stray;

  always @(posedge clk) begin
    pop_cnt <= bus.gen_pop ? pop_cnt + 1 : 0;
    if (model_hit) pt_cnt <= pt_cnt + 1;
  end

  // Scoreboard.
  exp_t        exp_q[$];
  int unsigned next_pt = 0;

  task automatic push_exp(input logic [ID_W-1:0] id, input logic good);
    exp_t e;
    e.id  = id;
    e.err = !good;
    if (good) begin
      e.d = point(next_pt);
      next_pt++;
    end else begin
      e.d = '0;
    end
    exp_q.push_back(e);
  endtask

  // Response monitor, sampled on the falling edge.
  logic        prev_rv = 1'b0;
  int unsigned pop_cycles = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.gen_pop) pop_cycles++;
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        check("ack_onehot", 32'(bus.ack), 32'(NUM_REQ'(1) << e.id));
        check("rsp_w", bus.rsp_w, e.d.w);
        check("rsp_x", bus.rsp_x, e.d.x);
        check("rsp_y", bus.rsp_y, e.d.y);
        check("rsp_z", bus.rsp_z, e.d.z);
      end
      check("rsp_single_cycle", 32'(prev_rv), 32'd0);
    end else if (bus.ack != '0) begin
      check("ack_without_rsp", 32'(bus.ack), 32'd0);
    end
    prev_rv = bus.rsp_valid;
  end

  task automatic wait_rsp(input string name, input int unsigned budget, output int unsigned n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid || n >= budget) break;
    end
    if (!bus.rsp_valid) check({name, "_wait_expired"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req        = '0;
    bus.cfg_reseed = 1'b0;
    bus.cfg_seed   = '0;
    lat            = 0;
    stray          = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  vec_t        tbl[7];
  int unsigned n;

  initial begin
    // Expected ids follow round-robin from ptr=0 after reset.
    tbl[0] = '{req: 4'b0001, lat: 5, id: 2'd0, err: 1'b0};
    tbl[1] = '{req: 4'b0101, lat: 2, id: 2'd2, err: 1'b0};
    tbl[2] = '{req: 4'b0101, lat: 3, id: 2'd0, err: 1'b0};
    tbl[3] = '{req: 4'b1000, lat: 1, id: 2'd3, err: 1'b0};
    tbl[4] = '{req: 4'b0110, lat: 4, id: 2'd1, err: 1'b0};
    tbl[5] = '{req: 4'b0011, lat: 0, id: 2'd0, err: 1'b1};
    tbl[6] = '{req: 4'b0011, lat: 2, id: 2'd1, err: 1'b0};

    // Reset state.
    do_reset();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_w", bus.rsp_w, 32'd0);
    check("rst_gen_pop", 32'(bus.gen_pop), 32'd0);
    check("rst_gen_reseed", 32'(bus.gen_reseed), 32'd0);
    check("rst_gen_seed", bus.gen_seed, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout_flag", 32'(bus.timeout_flag), 32'd0);

    // Single request: latency and gen_pop width.
    lat = 5;
    pop_cycles = 0;
    push_exp(2'd0, 1'b1);
    bus.req = 4'b0001;
    wait_rsp("single", 50, n);
    bus.req = '0;
    check("single_latency", n, 32'd7);
    check("single_pop_cycles", pop_cycles, 32'd6);
    @(negedge clk);
    check("single_pop_dropped", 32'(bus.gen_pop), 32'd0);

    // Table-driven grants.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      lat = tbl[i].lat;
      push_exp(tbl[i].id, !tbl[i].err);
      bus.req = tbl[i].req;
      wait_rsp("table", 200, n);
      bus.req = '0;
      @(negedge clk);
    end
    check("table_timeout_flag_sticky", 32'(bus.timeout_flag), 32'd1);

    // Timeout latency, then normal service with the flag still set (ptr=2).
    lat = 0;
    push_exp(2'd2, 1'b0);
    bus.req = 4'b0100;
    wait_rsp("timeout", 200, n);
    bus.req = '0;
    check("timeout_latency", n, TIMEOUT_CYC + 2);
    check("timeout_flag_set", 32'(bus.timeout_flag), 32'd1);
    @(negedge clk);
    lat = 3;
    push_exp(2'd2, 1'b1);
    bus.req = 4'b0100;
    wait_rsp("after_timeout", 50, n);
    bus.req = '0;
    check("timeout_flag_kept", 32'(bus.timeout_flag), 32'd1);
    @(negedge clk);

    // Fairness: all requesting, held across 8 responses.
    do_reset();
    lat = 2;
    for (int k = 0; k < 8; k++) push_exp(ID_W'(k % 4), 1'b1);
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_rsp("fair", 50, n);
      if (k > 0) check("fair_gap", n, 32'd5);
    end
    bus.req = '0;
    @(negedge clk);

    // Reseed during WAIT: current response first, then reseed, then req 1.
    do_reset();
    lat = 6;
    push_exp(2'd0, 1'b1);
    bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    check("reseed_busy_in_wait", 32'(bus.busy), 32'd1);
    bus.req        = 4'b0011;
    bus.cfg_reseed = 1'b1;
    bus.cfg_seed   = 32'd5;
    push_exp(2'd1, 1'b1);
    @(negedge clk);
    bus.cfg_reseed = 1'b0;
    bus.cfg_seed   = 32'hDEAD_BEEF;
    wait_rsp("reseed_first", 50, n);
    bus.req = 4'b0010;
    n = 0;
    while (!bus.gen_reseed && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reseed_pulse_seen", 32'(bus.gen_reseed), 32'd1);
    check("reseed_gap", n, 32'd2);
    check("reseed_seed", bus.gen_seed, 32'd5);
    check("reseed_before_req1", exp_q.size(), 32'd1);
    @(negedge clk);
    check("reseed_one_cycle", 32'(bus.gen_reseed), 32'd0);
    wait_rsp("reseed_second", 50, n);
    bus.req = '0;
    check("reseed_seed_held", bus.gen_seed, 32'd5);
    @(negedge clk);

    // Reset mid-WAIT: no ack, clean state, requester 0 first afterwards.
    do_reset();
    lat = 2;
    push_exp(2'd1, 1'b1);
    bus.req = 4'b0010;
    wait_rsp("pre_rst", 50, n);
    bus.req = '0;
    @(negedge clk);
    lat = 0;
    bus.req = 4'b0010;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_gen_pop", 32'(bus.gen_pop), 32'd0);
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rsp_w", bus.rsp_w, 32'd0);
    check("midrst_timeout_flag", 32'(bus.timeout_flag), 32'd0);
    rst = 1'b0;
    lat = 2;
    push_exp(2'd0, 1'b1);
    bus.req = 4'b1111;
    wait_rsp("post_rst", 50, n);
    bus.req = '0;
    @(negedge clk);

    // Stray gen_valid while idle is ignored.
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stray_busy", 32'(bus.busy), 32'd0);
      check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    stray = 1'b0;

`ifdef SPHERE3_POOL_ARBITER_STATS_EN
    // Three good responses to requester 2 plus one timeout.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      lat = (k < 3) ? 2 : 0;
      push_exp(2'd2, k < 3);
      bus.req = 4'b0100;
      wait_rsp("stats", 200, n);
      bus.req = '0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("stats_grant2", 32'(grant_cnt[2*16 +: 16]), 32'd3);
    check("stats_grant0", 32'(grant_cnt[0 +: 16]), 32'd0);
    check("stats_timeout", 32'(timeout_cnt), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
